// File: rtl/seq_lut_gen.sv
// seq_lut_gen: programmable sequence generator.
// A registered index walks a writable DEPTH x W lookup table and presents one
// entry per enabled clock, in one-shot or looping mode, with a selectable length.
// Optional feature macro: SEQ_LUT_GEN_DIR_EN adds a 'dir' input that is latched
// at start and allows the table to be walked in descending order.

module seq_lut_gen #(
   parameter int W     = 3,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          en,
   input  logic          loop,
   input  logic [AW:0]   len,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
`ifdef SEQ_LUT_GEN_DIR_EN
   input  logic          dir,
`endif
   output logic [W-1:0]  seq_out,
   output logic          seq_valid,
   output logic [AW-1:0] idx,
   output logic          busy,
   output logic          done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   state_t        r_state;
   state_t        w_stateNext;

   logic [W-1:0]  r_table [DEPTH];
   logic [W-1:0]  r_seqOut;
   logic          r_valid;
   logic [AW-1:0] r_idx;
   logic          r_done;
   logic [AW:0]   r_lenQ;
   logic          r_loopQ;

   logic [AW:0]   w_lenEff;
   logic [AW-1:0] w_startLast;
   logic [AW-1:0] w_lastIdx;
   logic [AW-1:0] w_wrapIdx;
   logic          w_atEnd;
   logic          w_dirIn;
   logic          w_desc;

   logic [AW-1:0] w_idxNext;
   logic          w_validNext;
   logic          w_doneNext;
   logic          w_load;
   logic          w_latch;

`ifdef SEQ_LUT_GEN_DIR_EN
   logic          r_dirQ;

   assign w_dirIn = dir;
   assign w_desc  = r_dirQ;

   // Direction is captured once at start and held for the whole sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dirQ <= 1'b0;
      end else if (w_latch) begin
         r_dirQ <= dir;
      end
   end
`else
   assign w_dirIn = 1'b0;
   assign w_desc  = 1'b0;
`endif

   // A length of zero or one beyond the table size selects the full table.
   assign w_lenEff    = (len == '0 || len > LEN_MAX) ? LEN_MAX : len;
   assign w_startLast = AW'(w_lenEff - 1'b1);
   assign w_lastIdx   = AW'(r_lenQ - 1'b1);

   // The end of a lap is index 0 when descending and len-1 when ascending;
   // wrapping jumps explicitly to the opposite end rather than relying on overflow.
   assign w_atEnd   = w_desc ? (r_idx == '0) : (r_idx == w_lastIdx);
   assign w_wrapIdx = w_desc ? w_lastIdx : '0;

   // State register for the IDLE/RUN controller.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and datapath control; stop outranks en, and start is only heard in IDLE.
   always_comb begin
      w_stateNext = r_state;
      w_idxNext   = r_idx;
      w_validNext = r_valid;
      w_doneNext  = 1'b0;
      w_load      = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !stop) begin
               w_stateNext = RUN;
               w_latch     = 1'b1;
               w_idxNext   = w_dirIn ? w_startLast : '0;
               w_load      = 1'b1;
               w_validNext = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               w_stateNext = IDLE;
               w_validNext = 1'b0;
            end else if (en) begin
               if (w_atEnd) begin
                  if (r_loopQ) begin
                     w_idxNext = w_wrapIdx;
                     w_load    = 1'b1;
                  end else begin
                     w_stateNext = IDLE;
                     w_validNext = 1'b0;
                     w_doneNext  = 1'b1;
                  end
               end else begin
                  w_idxNext = w_desc ? (r_idx - 1'b1) : (r_idx + 1'b1);
                  w_load    = 1'b1;
               end
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Output and sequence-parameter registers; the table read sees pre-write contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seqOut <= '0;
         r_valid  <= 1'b0;
         r_idx    <= '0;
         r_done   <= 1'b0;
         r_lenQ   <= LEN_MAX;
         r_loopQ  <= 1'b0;
      end else begin
         r_valid <= w_validNext;
         r_done  <= w_doneNext;
         r_idx   <= w_idxNext;
         if (w_load) begin
            r_seqOut <= r_table[w_idxNext];
         end
         if (w_latch) begin
            r_lenQ  <= w_lenEff;
            r_loopQ <= loop;
         end
      end
   end

   // Table storage: identity pattern on reset, writable in any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_table[i] <= W'(i);
         end
      end else if (wr_en) begin
         r_table[wr_addr] <= wr_data;
      end
   end

   assign seq_out   = r_seqOut;
   assign seq_valid = r_valid;
   assign idx       = r_idx;
   assign busy      = (r_state == RUN);
   assign done      = r_done;

endmodule
